// File: rtl/state_streamer.sv
// Byte-serial debug readout: snapshots one of CHANNELS status vectors in a single
// cycle and streams it as header, length, data and XOR checksum over valid/ready.
module state_streamer #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 128,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] chan_data,
  input  logic [3:0]                chan_sel,
  input  logic                      req,
  output logic [7:0]                out_byte,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      err
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned IW     = $clog2(NBYTES) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] LEN  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] CSUM = 3'd4;

  logic [2:0]       state, state_n;
  logic [WIDTH-1:0] snap, snap_n;
  logic [IW-1:0]    idx, idx_n;
  logic [7:0]       csum, csum_n;
  logic [7:0]       byte_n;
  logic             valid_n, last_n, busy_n, err_n;

  logic             xfer;
  logic             sel_ok;
  logic [WIDTH-1:0] chan_pick;
  logic [WIDTH-1:0] ordered;
  logic [IW-1:0]    idx_inc;

  assign xfer      = out_valid && out_ready;
  assign sel_ok    = 32'(chan_sel) < CHANNELS;
  assign chan_pick = WIDTH'(chan_data >> (32'(chan_sel) * WIDTH));
  assign idx_inc   = idx + IW'(1);

  // Reorder the snapshot so that transmit byte i always sits at ordered[8i +: 8].
  for (genvar i = 0; i < NBYTES; i++) begin : g_order
    if (MSB_FIRST) begin : g_msb
      assign ordered[8*i +: 8] = snap[WIDTH-1-8*i -: 8];
    end else begin : g_lsb
      assign ordered[8*i +: 8] = snap[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      snap      <= '0;
      idx       <= '0;
      csum      <= '0;
      out_byte  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      snap      <= snap_n;
      idx       <= idx_n;
      csum      <= csum_n;
      out_byte  <= byte_n;
      out_valid <= valid_n;
      out_last  <= last_n;
      busy      <= busy_n;
      err       <= err_n;
    end
  end

  // Next-state and next-output logic; everything holds unless a transfer or request moves it.
  always_comb begin
    state_n = state;
    snap_n  = snap;
    idx_n   = idx;
    csum_n  = csum;
    byte_n  = out_byte;
    valid_n = out_valid;
    last_n  = out_last;
    busy_n  = busy;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          if (sel_ok) begin
            state_n = HDR;
            snap_n  = chan_pick;
            idx_n   = '0;
            csum_n  = 8'h00;
            byte_n  = {4'hA, chan_sel};
            valid_n = 1'b1;
            last_n  = 1'b0;
            busy_n  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      HDR: begin
        if (xfer) begin
          state_n = LEN;
          csum_n  = csum ^ out_byte;
          byte_n  = 8'(NBYTES);
        end
      end
      LEN: begin
        if (xfer) begin
          state_n = DATA;
          csum_n  = csum ^ out_byte;
          idx_n   = '0;
          byte_n  = ordered[7:0];
        end
      end
      DATA: begin
        if (xfer) begin
          csum_n = csum ^ out_byte;
          if (idx == LAST_IDX) begin
            state_n = CSUM;
            byte_n  = csum ^ out_byte;
            last_n  = 1'b1;
          end else begin
            idx_n  = idx_inc;
            byte_n = 8'(ordered >> {idx_inc, 3'b000});
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_n = IDLE;
          byte_n  = 8'h00;
          valid_n = 1'b0;
          last_n  = 1'b0;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        byte_n  = 8'h00;
        valid_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
